// File: rtl/divider.sv
// divider: iterative 32-bit restoring divider, one quotient bit per clock.
// Result {remainder, quotient} is moved to dataOut on OUT, for HILO.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous reset, active low
//   dataA    dividend, sampled on the start edge only
//   dataB    divisor, sampled on the start edge only
//   Signal   6-bit ALU control code (DIVU starts, OUT transfers)
//   dataOut  {remainder, quotient}, registered, changes only on OUT/reset
//   busy     high while the 32 iterations run
//   done     high while a finished result waits for OUT
//
// Build option: define DIV_SIGNED_EN to honour the signed DIV code.
module divider #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  DIVU  = 6'b011011,
    parameter logic [5:0]  OUT   = 6'b111111
`ifdef DIV_SIGNED_EN
    ,
    parameter logic [5:0]  DIV   = 6'b011010
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    input  logic [5:0]         Signal,
    output logic [2*WIDTH-1:0] dataOut,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_div;
    logic [63:0] r_rq;
    logic [5:0]  r_cnt;

    logic        w_start;
    logic [31:0] w_div_ld;
    logic [31:0] w_dvd_ld;
    logic [32:0] w_t;
    logic [33:0] w_d;
    logic [63:0] w_rq_nxt;
    logic [63:0] w_fin;

`ifdef DIV_SIGNED_EN
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_zero;
    logic        w_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_rem;
    logic [31:0] w_quo;

    assign w_sgn   = (Signal == DIV);
    assign w_start = (Signal == DIVU) || w_sgn;
    assign w_a_neg = w_sgn && dataA[31];
    assign w_b_neg = w_sgn && dataB[31];
    // Magnitudes; 32'h80000000 maps onto itself, which is its
    // correct unsigned magnitude.
    assign w_dvd_ld = w_a_neg ? -dataA : dataA;
    assign w_div_ld = w_b_neg ? -dataB : dataB;
`else
    assign w_start  = (Signal == DIVU);
    assign w_dvd_ld = dataA;
    assign w_div_ld = dataB;
`endif

    // Shifted partial remainder keeps the bit leaving R's MSB, so the
    // compare stays correct for divisors >= 2^31.
    assign w_t = {r_rq[63:32], r_rq[31]};
    assign w_d = {1'b0, w_t} - {2'b00, r_div};

    always_comb begin
        w_rq_nxt = {w_t[31:0], r_rq[30:0], 1'b0};
        if (!w_d[33]) begin
            w_rq_nxt = {w_d[31:0], r_rq[30:0], 1'b1};
        end
    end

`ifdef DIV_SIGNED_EN
    // Sign fix-up applied once, on the last iteration.
    always_comb begin
        w_rem = w_rq_nxt[63:32];
        w_quo = w_rq_nxt[31:0];
        if (r_neg_r) begin
            w_rem = -w_rq_nxt[63:32];
        end
        if (r_neg_q) begin
            w_quo = -w_rq_nxt[31:0];
        end
        // Zero divisor: core leaves |A| as R, re-signed gives dataA.
        if (r_zero) begin
            w_quo = 32'hFFFF_FFFF;
        end
        w_fin = {w_rem, w_quo};
    end
`else
    assign w_fin = w_rq_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_div   <= 32'd0;
            r_rq    <= 64'd0;
            r_cnt   <= 6'd0;
            dataOut <= 64'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_div   <= w_div_ld;
                        r_rq    <= {32'd0, w_dvd_ld};
                        r_cnt   <= 6'd0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        r_state <= RUN;
`ifdef DIV_SIGNED_EN
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_zero  <= w_sgn && (dataB == 32'd0);
`endif
                    end else if (r_state == DONE
                                 && Signal == OUT) begin
                        dataOut <= r_rq;
                        done    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_rq    <= w_fin;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_rq <= w_rq_nxt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
